// File: rtl/divider_nbit.sv
// Iterative restoring unsigned divider: one quotient bit per clock, start/ready/done handshake.
// Includes the adder_nbit used for the trial subtraction.

module adder_nbit #(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);
    generate
        if (IMPL_TYPE == 0) begin : g_ripple
            logic [WIDTH-1:0] c;
            assign c[0] = cin;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign sum[i] = a[i] ^ b[i] ^ c[i];
                if (i < WIDTH - 1) begin : g_carry
                    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
                end
            end
        end else begin : g_behav
            assign sum = a + b + WIDTH'(cin);
        end
    endgenerate
endmodule

// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | resolving one quotient bit per cycle, ready=0
// DONE  | single-cycle done pulse, Q/R valid, new start accepted
module divider_nbit #(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};

    // rem_shift - divisor as rem_shift + ~divisor + 1 at WIDTH+1 bits; MSB is the borrow
    adder_nbit #(
        .WIDTH    (WIDTH + 1),
        .IMPL_TYPE(IMPL_TYPE)
    ) u_sub (
        .a  (rem_shift),
        .b  (~{1'b0, div_q}),
        .cin(1'b1),
        .sum(trial)
    );

    assign borrow   = trial[WIDTH];
    assign rem_next = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    if (start) begin
                        quo_q <= A;
                        div_q <= B;
                        rem_q <= '0;
                        cnt   <= CW'(WIDTH);
                        if (B == '0) begin
                            // no iterations needed: result is fixed by convention
                            state       <= DONE;
                            done        <= 1'b1;
                            Q           <= '1;
                            R           <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            ready <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        ready       <= 1'b1;
                        done        <= 1'b1;
                        Q           <= quo_next;
                        R           <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_nbit.sv
// Scoreboard bench for divider_nbit: directed cases on an 8-bit instance, random on 8- and 32-bit.

module tb_divider_nbit;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, done8, dbz8;
    logic [7:0]  q8, r8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ready32, done32, dbz32;
    logic [31:0] q32, r32;

    exp_t sb8[$];
    exp_t sb32[$];

    int n_checks = 0;
    int n_errors = 0;

    divider_nbit #(.WIDTH(8), .IMPL_TYPE(0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .ready(ready8), .done(done8), .Q(q8), .R(r8), .div_by_zero(dbz8)
    );

    divider_nbit #(.WIDTH(32), .IMPL_TYPE(1)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32),
        .ready(ready32), .done(done32), .Q(q32), .R(r32), .div_by_zero(dbz32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                check_val("w8_spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                check_val("w8_q", {24'd0, q8}, e.q);
                check_val("w8_r", {24'd0, r8}, e.r);
                check_val("w8_dbz", {31'd0, dbz8}, {31'd0, e.dbz});
                check_val("w8_done_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done32) begin
            if (sb32.size() == 0) begin
                check_val("w32_spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb32.pop_front();
                check_val("w32_q", q32, e.q);
                check_val("w32_r", r32, e.r);
                check_val("w32_dbz", {31'd0, dbz32}, {31'd0, e.dbz});
                check_val("w32_done_cycle", cyc, e.due);
            end
        end
    end

    // Entered at a negedge; returns at the negedge after start was driven.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        int   guard = 0;
        exp_t e;
        while (!ready8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready8) check_val("w8_ready_timeout", {31'd0, ready8}, 32'd1);
        a8 = a; b8 = b; start8 = 1'b1;
        e.q   = (b == 0) ? 32'hFF : 32'(a / b);
        e.r   = (b == 0) ? 32'(a) : 32'(a % b);
        e.dbz = (b == 0);
        e.due = (b == 0) ? cyc + 1 : cyc + 9;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b);
        int   guard = 0;
        exp_t e;
        while (!ready32 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready32) check_val("w32_ready_timeout", {31'd0, ready32}, 32'd1);
        a32 = a; b32 = b; start32 = 1'b1;
        e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.dbz = (b == 0);
        e.due = (b == 0) ? cyc + 1 : cyc + 33;
        sb32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic drain(input int idle_after);
        int guard = 0;
        while ((sb8.size() != 0 || sb32.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_val("drain_pending", sb8.size() + sb32.size(), 32'd0);
        repeat (idle_after) @(negedge clk);
    endtask

    function automatic logic [31:0] pick(input int width);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (width == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = mask;
            3:       v = mask - 32'd1;
            4:       v = $urandom_range(0, 15);
            5:       v = $urandom() >> $urandom_range(0, 31);
            default: v = $urandom();
        endcase
        return v & mask;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_q", {24'd0, q8}, 32'd0);
        check_val("reset_r", {24'd0, r8}, 32'd0);
        check_val("reset_done", {31'd0, done8}, 32'd0);
        check_val("reset_dbz", {31'd0, dbz8}, 32'd0);
        check_val("reset_ready", {31'd0, ready8}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with ready profile
        issue8(8'd100, 8'd7);
        for (int i = 0; i < 8; i++) begin
            check_val("busy_ready_low", {31'd0, ready8}, 32'd0);
            @(negedge clk);
        end
        check_val("ready_high_in_done", {31'd0, ready8}, 32'd1);

        // back-to-back: second issued in the DONE cycle
        issue8(8'd255, 8'd1);
        issue8(8'd3, 8'd200);
        drain(2);

        // divide by zero followed by normal divide
        issue8(8'd5, 8'd0);
        issue8(8'd9, 8'd3);
        drain(2);
        check_val("hold_q", {24'd0, q8}, 32'd3);
        check_val("hold_dbz", {31'd0, dbz8}, 32'd0);

        // start while busy is ignored, operand changes have no effect
        issue8(8'd200, 8'd9);
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
        drain(12);

        // asynchronous reset mid-division
        issue8(8'd100, 8'd7);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_q", {24'd0, q8}, 32'd0);
        check_val("midrst_r", {24'd0, r8}, 32'd0);
        check_val("midrst_done", {31'd0, done8}, 32'd0);
        check_val("midrst_ready", {31'd0, ready8}, 32'd1);
        sb8.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue8(8'd50, 8'd6);
        drain(12);

        // random regression
        for (int i = 0; i < 500; i++) begin
            issue8(8'(pick(8)), 8'(pick(8)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain(2);
        for (int i = 0; i < 300; i++) begin
            issue32(pick(32), pick(32));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
